// File: rtl/tail_light_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_decoder
// Description : Receive-side monitor for the 3-bit left/right tail-light
//               sequence (000 -> 001 -> 011 -> 111 -> 000). It tracks the
//               phase of each side, pulses on every completed blink cycle,
//               counts completed cycles, and latches the first protocol error.
// Ports       : clk           rising-edge clock
//               reset         asynchronous, active-high; clears all state
//               lights_l/_r   lamp buses, sampled every rising edge
//               clear         synchronous clear of err, err_code, cnt_l, cnt_r
//               active_l/_r   tracker in phase P1..P3
//               done_l/_r     one-cycle pulse on a completed sequence
//               cnt_l/_r      completed-sequence counters (wrap)
//               err           sticky error flag
//               err_code      first error: 01 invalid, 10 transition, 11 overlap
// Revision    : 1.0 - initial release
// ============================================================================
module tail_light_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       lights_l,
    input  logic [2:0]       lights_r,
    input  logic             clear,
    output logic             active_l,
    output logic             active_r,
    output logic             done_l,
    output logic             done_r,
    output logic [CNT_W-1:0] cnt_l,
    output logic [CNT_W-1:0] cnt_r,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_P1     = 3'd1;
    localparam logic [2:0] c_ST_P2     = 3'd2;
    localparam logic [2:0] c_ST_P3     = 3'd3;
    localparam logic [2:0] c_ST_RESYNC = 3'd4;

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_INVALID = 2'b01;
    localparam logic [1:0] c_ERR_TRANS   = 2'b10;
    localparam logic [1:0] c_ERR_OVERLAP = 2'b11;

    logic [2:0]       w_sample [2];
    logic             w_overlap;
    logic [1:0]       w_invalid;
    logic [1:0]       w_trans;
    logic [1:0]       w_active;
    logic [1:0]       w_done;
    logic [CNT_W-1:0] w_cnt [2];

    assign w_sample[0] = lights_l;
    assign w_sample[1] = lights_r;

    // Both lamps lit in the same sample is never legal.
    assign w_overlap = (|lights_l) & (|lights_r);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            logic [2:0]       r_state;
            logic [2:0]       w_state_next;
            logic             w_is_invalid;
            logic             w_trans_evt;
            logic             w_done_evt;
            logic             w_active_i;
            logic             r_done;
            logic [CNT_W-1:0] r_cnt;

            always_comb begin
                w_is_invalid = !((w_sample[gi] == 3'b000) || (w_sample[gi] == 3'b001) ||
                                 (w_sample[gi] == 3'b011) || (w_sample[gi] == 3'b111));
            end

            // State register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= c_ST_IDLE;
                end else begin
                    r_state <= w_state_next;
                end
            end

            // Next-state logic. Overlap and invalid codes override the
            // phase logic; transition errors are suppressed in RESYNC.
            always_comb begin
                w_state_next = r_state;
                w_trans_evt  = 1'b0;
                w_done_evt   = 1'b0;
                if (w_overlap || w_is_invalid) begin
                    w_state_next = c_ST_RESYNC;
                end else begin
                    case (r_state)
                        c_ST_IDLE: begin
                            if (w_sample[gi] == 3'b001) begin
                                w_state_next = c_ST_P1;
                            end else if (w_sample[gi] != 3'b000) begin
                                w_trans_evt  = 1'b1;
                                w_state_next = c_ST_RESYNC;
                            end
                        end
                        c_ST_P1: begin
                            if (w_sample[gi] == 3'b011) begin
                                w_state_next = c_ST_P2;
                            end else begin
                                w_trans_evt  = 1'b1;
                                w_state_next = c_ST_RESYNC;
                            end
                        end
                        c_ST_P2: begin
                            if (w_sample[gi] == 3'b111) begin
                                w_state_next = c_ST_P3;
                            end else begin
                                w_trans_evt  = 1'b1;
                                w_state_next = c_ST_RESYNC;
                            end
                        end
                        c_ST_P3: begin
                            if (w_sample[gi] == 3'b000) begin
                                w_state_next = c_ST_IDLE;
                                w_done_evt   = 1'b1;
                            end else begin
                                w_trans_evt  = 1'b1;
                                w_state_next = c_ST_RESYNC;
                            end
                        end
                        c_ST_RESYNC: begin
                            if (w_sample[gi] == 3'b000) begin
                                w_state_next = c_ST_IDLE;
                            end
                        end
                        default: begin
                            w_state_next = c_ST_IDLE;
                        end
                    endcase
                end
            end

            // Output logic
            always_comb begin
                w_active_i = (r_state == c_ST_P1) || (r_state == c_ST_P2) ||
                             (r_state == c_ST_P3);
            end

            // Done pulse and wrapping counter; clear takes effect before the
            // same-cycle increment so a coincident done leaves the count at 1.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_done <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_done <= w_done_evt;
                    r_cnt  <= (clear ? '0 : r_cnt) + CNT_W'(w_done_evt);
                end
            end

            assign w_invalid[gi] = w_is_invalid;
            assign w_trans[gi]   = w_trans_evt;
            assign w_active[gi]  = w_active_i;
            assign w_done[gi]    = r_done;
            assign w_cnt[gi]     = r_cnt;
        end
    endgenerate

    logic [1:0] w_evt_code;
    logic       w_err_base;
    logic       w_err_next;
    logic [1:0] w_code_next;
    logic       r_err;
    logic [1:0] r_err_code;

    // Priority: overlap > invalid code > illegal transition.
    always_comb begin
        w_evt_code = c_ERR_NONE;
        if (w_overlap) begin
            w_evt_code = c_ERR_OVERLAP;
        end else if (|w_invalid) begin
            w_evt_code = c_ERR_INVALID;
        end else if (|w_trans) begin
            w_evt_code = c_ERR_TRANS;
        end
    end

    // First error since reset/clear wins the code register.
    always_comb begin
        w_err_base  = clear ? 1'b0 : r_err;
        w_err_next  = w_err_base;
        w_code_next = clear ? c_ERR_NONE : r_err_code;
        if (w_evt_code != c_ERR_NONE) begin
            w_err_next = 1'b1;
            if (!w_err_base) begin
                w_code_next = w_evt_code;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
        end else begin
            r_err      <= w_err_next;
            r_err_code <= w_code_next;
        end
    end

    assign active_l = w_active[0];
    assign active_r = w_active[1];
    assign done_l   = w_done[0];
    assign done_r   = w_done[1];
    assign cnt_l    = w_cnt[0];
    assign cnt_r    = w_cnt[1];
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_tail_light_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tail_light_decoder
// Description : Self-checking bench for tail_light_decoder. Two instances
//               (8-bit and 2-bit counters) share stimulus; a sequence-index
//               reference model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tail_light_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] lights_l = 3'b000;
    logic [2:0] lights_r = 3'b000;
    logic       clear = 1'b0;

    logic       active_l, active_r, done_l, done_r, err;
    logic [1:0] err_code;
    logic [7:0] cnt_l, cnt_r;

    logic       w_active_l, w_active_r, w_done_l, w_done_r, w_err;
    logic [1:0] w_err_code;
    logic [1:0] w_cnt_l, w_cnt_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tail_light_decoder #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .lights_l(lights_l), .lights_r(lights_r),
        .clear(clear), .active_l(active_l), .active_r(active_r),
        .done_l(done_l), .done_r(done_r), .cnt_l(cnt_l), .cnt_r(cnt_r),
        .err(err), .err_code(err_code)
    );

    tail_light_decoder #(.CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .lights_l(lights_l), .lights_r(lights_r),
        .clear(clear), .active_l(w_active_l), .active_r(w_active_r),
        .done_l(w_done_l), .done_r(w_done_r), .cnt_l(w_cnt_l), .cnt_r(w_cnt_r),
        .err(w_err), .err_code(w_err_code)
    );

    // ---------------- reference model ----------------
    // Each side is an index into the expected code sequence, plus a
    // "waiting for 000" flag after any error.
    localparam logic [2:0] SEQ [4] = '{3'b001, 3'b011, 3'b111, 3'b000};

    int         m_idx [2];
    bit         m_wait [2];
    bit         m_done [2];
    logic [7:0] m_cnt [2];
    bit         m_err;
    logic [1:0] m_code;

    logic [2:0] ms [2];
    bit         m_ov, m_inv_any, m_tr_any, m_bad_code;
    logic [1:0] m_evt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_idx[i] = 0; m_wait[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
            end
            m_err = 0; m_code = 0;
        end else begin
            ms[0] = lights_l; ms[1] = lights_r;
            m_ov = (ms[0] != 0) && (ms[1] != 0);
            m_inv_any = 0; m_tr_any = 0;
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 0;
                m_bad_code = !(ms[i] == 0 || ms[i] == 1 || ms[i] == 3 || ms[i] == 7);
                if (m_ov || m_bad_code) begin
                    m_inv_any = m_inv_any | m_bad_code;
                    m_wait[i] = 1; m_idx[i] = 0;
                end else if (m_wait[i]) begin
                    if (ms[i] == 0) m_wait[i] = 0;
                end else if (m_idx[i] == 0 && ms[i] == 0) begin
                    // idle, nothing to do
                end else if (ms[i] == SEQ[m_idx[i]]) begin
                    if (m_idx[i] == 3) begin
                        m_idx[i] = 0; m_done[i] = 1;
                    end else begin
                        m_idx[i] = m_idx[i] + 1;
                    end
                end else begin
                    m_tr_any = 1; m_wait[i] = 1; m_idx[i] = 0;
                end
            end
            m_evt = m_ov ? 2'd3 : m_inv_any ? 2'd1 : m_tr_any ? 2'd2 : 2'd0;
            if (clear) begin
                m_err = 0; m_code = 0; m_cnt[0] = 0; m_cnt[1] = 0;
            end
            for (int i = 0; i < 2; i++) m_cnt[i] = m_cnt[i] + 8'(m_done[i]);
            if (m_evt != 0) begin
                if (!m_err) m_code = m_evt;
                m_err = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [23:0] exp_v, got_v, got_w, exp_w;
    always @(negedge clk) begin
        exp_v = {m_idx[0] != 0, m_idx[1] != 0, m_done[0], m_done[1], m_cnt[0], m_cnt[1], m_err, m_code, 1'b0};
        got_v = {active_l, active_r, done_l, done_r, cnt_l, cnt_r, err, err_code, 1'b0};
        exp_w = {12'd0, m_idx[0] != 0, m_idx[1] != 0, m_done[0], m_done[1], m_cnt[0][1:0], m_cnt[1][1:0], m_err, m_code, 1'b0};
        got_w = {12'd0, w_active_l, w_active_r, w_done_l, w_done_r, w_cnt_l, w_cnt_r, w_err, w_err_code, 1'b0};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, got_v, exp_v);
        end
        total++;
        if (got_w !== exp_w) begin
            bad++;
            $display("FAIL cycle_cmp_w2 t=%0t got=%h want=%h", $time, got_w, exp_w);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Outputs seen right after cyc() returns reflect the previously applied values.
    task automatic cyc(input logic [2:0] l, input logic [2:0] r, input logic c, input logic rs);
        @(posedge clk);
        #2;
        lights_l = l; lights_r = r; clear = c; reset = rs;
    endtask

    task automatic do_reset();
        cyc(3'b000, 3'b000, 1'b0, 1'b1);
        cyc(3'b000, 3'b000, 1'b0, 1'b1);
        cyc(3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic seq_l();
        for (int i = 0; i < 4; i++) cyc(SEQ[i], 3'b000, 1'b0, 1'b0);
    endtask

    task automatic seq_r();
        for (int i = 0; i < 4; i++) cyc(3'b000, SEQ[i], 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    int         k, st, side;
    logic [2:0] vl, vr, v;

    initial begin
        // Reset state
        do_reset();
        chk("rst_active_l", int'(active_l), 0);
        chk("rst_cnt_l", int'(cnt_l), 0);
        chk("rst_err", int'(err), 0);

        // Single left sequence with explicit phase checks
        cyc(3'b001, 0, 0, 0);
        cyc(3'b011, 0, 0, 0);
        cyc(3'b111, 0, 0, 0);
        chk("left_active_p1", int'(active_l), 1);
        cyc(3'b000, 0, 0, 0);
        chk("left_active_p3", int'(active_l), 1);
        chk("left_nodone_p3", int'(done_l), 0);
        cyc(3'b000, 0, 0, 0);
        chk("left_done", int'(done_l), 1);
        chk("left_cnt", int'(cnt_l), 1);
        chk("left_idle", int'(active_l), 0);
        cyc(3'b000, 0, 0, 0);
        chk("left_done_once", int'(done_l), 0);
        chk("left_err", int'(err), 0);

        // Alternating back-to-back
        do_reset();
        for (int n = 0; n < 3; n++) begin
            seq_l();
            seq_r();
        end
        cyc(0, 0, 0, 0);
        chk("alt_cnt_l", int'(cnt_l), 3);
        chk("alt_cnt_r", int'(cnt_r), 3);
        chk("alt_err", int'(err), 0);

        // Skipped phase on right
        do_reset();
        cyc(0, 3'b001, 0, 0);
        cyc(0, 3'b111, 0, 0);
        cyc(0, 3'b011, 0, 0);
        chk("skip_err", int'(err), 1);
        chk("skip_code", int'(err_code), 2);
        cyc(0, 3'b000, 0, 0);
        chk("skip_resync_code", int'(err_code), 2);
        chk("skip_resync_active", int'(active_r), 0);
        seq_r();
        cyc(0, 0, 0, 0);
        chk("skip_cnt_r", int'(cnt_r), 1);
        chk("skip_err_sticky", int'(err), 1);

        // Overlap plus invalid code, then clear
        do_reset();
        cyc(3'b001, 3'b110, 0, 0);
        cyc(3'b010, 3'b000, 0, 0);
        chk("ovl_code", int'(err_code), 3);
        cyc(0, 0, 0, 0);
        chk("ovl_code_kept", int'(err_code), 3);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("clr_err", int'(err), 0);
        chk("clr_code", int'(err_code), 0);

        // Wrap on the 2-bit instance
        do_reset();
        for (int n = 0; n < 5; n++) begin
            seq_l();
            cyc(0, 0, 0, 0);
            chk("wrap_cnt_l", int'(w_cnt_l), (n + 1) % 4);
        end

        // Clear coincident with done
        do_reset();
        seq_l();
        cyc(3'b001, 0, 0, 0);
        cyc(3'b011, 0, 0, 0);
        cyc(3'b111, 0, 0, 0);
        cyc(3'b000, 0, 1, 0);
        cyc(3'b000, 0, 0, 0);
        chk("clr_done_cnt", int'(cnt_l), 1);

        // Reset at P2, then 011 judged from IDLE
        cyc(3'b001, 0, 0, 0);
        cyc(3'b011, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("p2_active", int'(active_l), 1);
        reset = 1'b1;
        #1;
        chk("arst_active", int'(active_l), 0);
        chk("arst_cnt", int'(cnt_l), 0);
        chk("arst_err", int'(err), 0);
        cyc(3'b011, 0, 0, 0);
        cyc(3'b000, 0, 0, 0);
        chk("post_rst_code", int'(err_code), 2);

        // Randomized traffic
        do_reset();
        st = 0; side = 0;
        for (int n = 0; n < 800; n++) begin
            k = $urandom_range(0, 99);
            vl = 0; vr = 0;
            if (k < 6) begin
                vl = 3'($urandom_range(0, 7));
                vr = 3'($urandom_range(0, 7));
            end else begin
                v = SEQ[st];
                if (k < 9) v = SEQ[(st + 1) % 4];
                if (side == 0) vl = v; else vr = v;
                st = (st + 1) % 4;
                if (st == 0) side = $urandom_range(0, 1);
            end
            cyc(vl, vr, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tail_light_decoder.md
Name: tail_light_decoder

Overview:
- Receive-side checker for the 3-bit left/right tail-light sequence produced by the turn-signal FSM.
- Samples both lamp buses every clock and tracks the phase of each side.
- Reports active sequences, pulses on each completed blink cycle and counts them.
- Flags protocol violations with a sticky error and a first-error code. Sits beside the FSM in the lab top level and in benches as a self-checking monitor.

Parameters:
CNT_W, 8, width of per-side completed-cycle counters

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
lights_l  input  3  left lamp bus (sampled on posedge clk)
lights_r  input  3  right lamp bus (sampled on posedge clk)
clear  input  1  synchronous clear of err, err_code, cnt_l, cnt_r
active_l  output  1  left tracker in phase P1..P3
active_r  output  1  right tracker in phase P1..P3
done_l  output  1  one-cycle pulse: left sequence completed
done_r  output  1  one-cycle pulse: right sequence completed
cnt_l  output  CNT_W  completed left sequences, wraps
cnt_r  output  CNT_W  completed right sequences, wraps
err  output  1  sticky protocol-error flag
err_code  output  2  code of first error since reset/clear

Behaviour:
- Reset: every tracker goes to IDLE. All outputs are 0.
- Legal codes are 000, 001, 011, 111. All outputs are registered and reflect the sample taken at the same edge (1-cycle latency from bus change).
- Per-side tracker states and transitions, on sample s:
  - IDLE: s=000 stays IDLE; s=001 goes to P1; other legal codes give a transition error and go to RESYNC.
  - P1: s=011 goes to P2; else error and RESYNC.
  - P2: s=111 goes to P3; else error and RESYNC.
  - P3: s=000 goes to IDLE, asserts done_x for one cycle and increments cnt_x; else error and RESYNC.
  - RESYNC: stays until s=000, then goes to IDLE. Produces no further transition errors while waiting.
- Invalid code (010, 100, 101, 110) is error code 01; the tracker goes to RESYNC from any state.
- Illegal transition is error code 10.
- Overlap (lights_l != 000 and lights_r != 000 in the same sample) is error code 11. Both trackers go to RESYNC.
- Code priority within one cycle: 11 > 01 > 10.
- err sets on the first error. err_code latches only when err is 0 (first error wins); later errors leave err_code unchanged.
- active_x = tracker in P1, P2 or P3. It is 0 in IDLE and RESYNC.
- Counters wrap: all-ones + 1 = 0. No saturation, no flag.
- clear: resets err, err_code, cnt_l, cnt_r first, then applies same-cycle events. A done in the clear cycle gives cnt=1; an error in the clear cycle gives err=1 with that code. Trackers and active/done are unaffected by clear.
- Reset mid-sequence: asynchronous return to IDLE with outputs 0. The next sample is judged from IDLE, so a bus at 011 right after reset gives error 10.
- Back-to-back sequences: 111, 000, 001 is legal (P3 to IDLE to P1), with done on the 000 sample.
- Left and right trackers are independent apart from the overlap check.

Test Plan:
- Left sequence: reset, then lights_l 000,001,011,111,000, lights_r=000 -> active_l=1 for 3 cycles, done_l pulses once on the 000 sample, cnt_l=1, err=0.
- Alternating: left sequence, then right sequence, back-to-back, repeated 3 times each -> cnt_l=3, cnt_r=3, err=0, no active overlap.
- Skipped phase: lights_r 000,001,111 -> err=1, err_code=10 at the 111 sample. Tracker waits in RESYNC and ignores 011. After 000, a full right sequence gives cnt_r=1 with err still 1.
- Overlap plus invalid code: lights_l=001 and lights_r=110 in the same sample -> err_code=11 (priority). A later invalid 010 leaves err_code=11. clear gives err=0 and err_code=00.
- Wrap: CNT_W=2, five left sequences -> cnt_l sequence 1,2,3,0,1.
- Clear coincident with done, and reset mid-sequence: clear asserted on the done sample gives cnt_l=1. Reset asserted at P2 clears active_l asynchronously, and cnt_l and err return to 0.
